mem_access_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register: takes its control and data outputs and performs the data-memory access for one instruction at a time.
- Drives a req/ack memory bus and stalls the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding.
- Registers the MEM/WB pipeline fields, inserting a bubble on every stalled cycle.
- Non-memory instructions pass through with one-cycle latency and no stall.

---
 rtl/mem_access_stage.sv | 135 +++++++++++++
 tb/tb_mem_access_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs one data-memory access at a time on a req/ack bus, freezes upstream while it is outstanding.
// Non-memory ops retire in 1 cycle; aligned accesses take 1 + N cycles (N = WAIT cycles up to and including the ack).
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WB_in,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALU_in,
  input  logic [31:0] RDdata2_in,
  input  logic [4:0]  instruction_mux_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [1:0]  WB_out,
  output logic [31:0] Read_data_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  instruction_mux_out,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_req_q, mem_we_q, align_err_q, bus_err_q;
  logic [31:0]   mem_addr_q, mem_wdata_q, rdata_q, alu_q;
  logic [1:0]    wb_q;
  logic [4:0]    dst_q;

  logic access, aligned, ack_v, tmo_hit, both_set;

  assign access   = MemRead | MemWrite;
  assign aligned  = (ALU_in[1:0] == 2'b00);
  assign both_set = MemRead & MemWrite;
  // An ack is only meaningful while a request is actually on the bus.
  assign ack_v    = mem_ack & mem_req_q;
  assign tmo_hit  = TMO_EN && (cnt_q == TMO_LAST);

  // Gated by reset so that stall drops immediately with the asynchronous reset.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      case (state_q)
        S_IDLE:  stall = access & aligned;
        S_WAIT:  stall = ~ack_v & ~tmo_hit;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_q        <= '0;
      rdata_q     <= '0;
      alu_q       <= '0;
      dst_q       <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (access && aligned) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= MemWrite;
            mem_addr_q  <= ALU_in;
            mem_wdata_q <= RDdata2_in;
            cnt_q       <= '0;
            wb_q        <= '0;
            state_q     <= S_WAIT;
          end else begin
            wb_q        <= access ? 2'b00 : WB_in;
            alu_q       <= ALU_in;
            dst_q       <= instruction_mux_in;
            rdata_q     <= '0;
            align_err_q <= access;
          end
        end
        S_WAIT: begin
          if (ack_v) begin
            mem_req_q <= 1'b0;
            wb_q      <= both_set ? 2'b00 : WB_in;
            alu_q     <= ALU_in;
            dst_q     <= instruction_mux_in;
            rdata_q   <= mem_we_q ? 32'd0 : mem_rdata;
            state_q   <= S_IDLE;
          end else if (tmo_hit) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            wb_q      <= '0;
            alu_q     <= ALU_in;
            dst_q     <= instruction_mux_in;
            rdata_q   <= '0;
            state_q   <= S_IDLE;
          end else begin
            wb_q  <= '0;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req             = mem_req_q;
  assign mem_we              = mem_we_q;
  assign mem_addr            = mem_addr_q;
  assign mem_wdata           = mem_wdata_q;
  assign WB_out              = wb_q;
  assign Read_data_out       = rdata_q;
  assign ALU_out             = alu_q;
  assign instruction_mux_out = dst_q;
  assign align_err           = align_err_q;
  assign bus_err             = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short bus timeout (4 WAIT cycles).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  WB_in;
  logic        MemRead, MemWrite;
  logic [31:0] ALU_in, RDdata2_in;
  logic [4:0]  instruction_mux_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [1:0]  WB_out;
  logic [31:0] Read_data_out, ALU_out;
  logic [4:0]  instruction_mux_out;
  logic        align_err, bus_err;

  int n_checks = 0;
  int n_errors = 0;
  int stalls;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .WB_in(WB_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALU_in(ALU_in), .RDdata2_in(RDdata2_in), .instruction_mux_in(instruction_mux_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .WB_out(WB_out),
    .Read_data_out(Read_data_out), .ALU_out(ALU_out), .instruction_mux_out(instruction_mux_out),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] wb, input logic [4:0] dst);
    MemRead = rd; MemWrite = wr; ALU_in = addr; RDdata2_in = wdata;
    WB_in = wb; instruction_mux_in = dst;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
  endtask

  // Called at a negedge; returns at the negedge after the retiring edge with inputs set to a NOP.
  // gap = WAIT cycles without ack before the ack cycle; -1 never acks.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] wb, input logic [4:0] dst,
                        input int gap, input logic [31:0] rdata, output int n_stall);
    logic done;
    n_stall = 0;
    done = 1'b0;
    drive(rd, wr, addr, wdata, wb, dst);
    for (int c = 0; c < 40 && !done; c++) begin
      if (gap >= 0 && c == gap + 1) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      #1;
      if (stall) n_stall++;
      if (c >= 1) begin
        check({tag, "_wait_req"}, 32'(mem_req), 32'd1);
        check({tag, "_wait_wb"}, 32'(WB_out), 32'd0);
        if (c == 1) begin
          check({tag, "_we"}, 32'(mem_we), 32'(wr));
          check({tag, "_addr"}, mem_addr, addr);
          check({tag, "_wdata"}, mem_wdata, wdata);
        end
      end
      done = !stall;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
    end
    check({tag, "_retired"}, 32'(done), 32'd1);
    nop();
  endtask

  initial begin
    reset = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    nop();
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb", 32'(WB_out), 32'd0);
    check("rst_alu", ALU_out, 32'd0);
    check("rst_rd", Read_data_out, 32'd0);
    check("rst_errs", {30'd0, align_err, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Plain ALU op
    drive(1'b0, 1'b0, 32'h1234, 32'h0, 2'b10, 5'd5);
    #1 check("alu_stall", 32'(stall), 32'd0);
    @(posedge clk); @(negedge clk);
    check("alu_wb", 32'(WB_out), 32'd2);
    check("alu_res", ALU_out, 32'h1234);
    check("alu_dst", 32'(instruction_mux_out), 32'd5);
    check("alu_rd", Read_data_out, 32'd0);
    check("alu_req", 32'(mem_req), 32'd0);

    // Load, ack 3 cycles after req; counter is at its last value, so ack must beat timeout
    run_op("ld", 1'b1, 1'b0, 32'h100, 32'h0, 2'b01, 5'd7, 3, 32'hDEADBEEF, stalls);
    check("ld_stalls", 32'(stalls), 32'd4);
    check("ld_data", Read_data_out, 32'hDEADBEEF);
    check("ld_wb", 32'(WB_out), 32'd1);
    check("ld_alu", ALU_out, 32'h100);
    check("ld_dst", 32'(instruction_mux_out), 32'd7);
    check("ld_req", 32'(mem_req), 32'd0);
    check("ld_buserr", 32'(bus_err), 32'd0);

    // Store acked in first WAIT cycle
    run_op("st", 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 2'b00, 5'd3, 0, 32'h77777777, stalls);
    check("st_stalls", 32'(stalls), 32'd1);
    check("st_rd", Read_data_out, 32'd0);
    check("st_req", 32'(mem_req), 32'd0);
    check("st_wb", 32'(WB_out), 32'd0);

    // Misaligned load
    run_op("mis", 1'b1, 1'b0, 32'h102, 32'h0, 2'b11, 5'd9, -1, 32'h0, stalls);
    check("mis_stalls", 32'(stalls), 32'd0);
    check("mis_aerr", 32'(align_err), 32'd1);
    check("mis_wb", 32'(WB_out), 32'd0);
    check("mis_alu", ALU_out, 32'h102);
    check("mis_dst", 32'(instruction_mux_out), 32'd9);
    check("mis_req", 32'(mem_req), 32'd0);
    @(posedge clk); @(negedge clk);
    check("mis_aerr_clr", 32'(align_err), 32'd0);

    // Load that never gets an ack
    run_op("tmo", 1'b1, 1'b0, 32'h300, 32'h0, 2'b01, 5'd4, -1, 32'h0, stalls);
    check("tmo_stalls", 32'(stalls), 32'd4);
    check("tmo_berr", 32'(bus_err), 32'd1);
    check("tmo_req", 32'(mem_req), 32'd0);
    check("tmo_wb", 32'(WB_out), 32'd0);
    drive(1'b0, 1'b0, 32'h55, 32'h0, 2'b10, 5'd2);
    #1 check("tmo_next_stall", 32'(stall), 32'd0);
    @(posedge clk); @(negedge clk);
    check("tmo_berr_clr", 32'(bus_err), 32'd0);
    check("tmo_next_wb", 32'(WB_out), 32'd2);
    check("tmo_next_alu", ALU_out, 32'h55);
    nop();

    // Read and write both set: write wins, no writeback
    run_op("both", 1'b1, 1'b1, 32'h40, 32'h12345678, 2'b11, 5'd8, 1, 32'hFFFF0000, stalls);
    check("both_stalls", 32'(stalls), 32'd2);
    check("both_wb", 32'(WB_out), 32'd0);
    check("both_rd", Read_data_out, 32'd0);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hABCD0123;
    drive(1'b0, 1'b0, 32'h9, 32'h0, 2'b01, 5'd1);
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("idle_ack_rd", Read_data_out, 32'd0);
    check("idle_ack_req", 32'(mem_req), 32'd0);
    check("idle_ack_wb", 32'(WB_out), 32'd1);

    // Asynchronous reset in the middle of an access
    drive(1'b1, 1'b0, 32'h400, 32'h0, 2'b01, 5'd6);
    @(posedge clk); @(negedge clk);
    check("ar_req_before", 32'(mem_req), 32'd1);
    check("ar_stall_before", 32'(stall), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_req_async", 32'(mem_req), 32'd0);
    check("ar_stall_async", 32'(stall), 32'd0);
    nop();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111;
    #1 check("ar_late_stall", 32'(stall), 32'd0);
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    check("ar_late_rd", Read_data_out, 32'd0);
    check("ar_late_req", 32'(mem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
